// File: rtl/deinterleaver_if.sv
// Bit-stream bundle between the receive front end and the deinterleaver.
// master drives the coded-bit stream and Flush; slave is the deinterleaver.
interface deinterleaver_if;
   logic       In_Valid;
   logic       In_Bit;
   logic       Flush;
   logic       Out_Valid;
   logic       Out_Bit;
   logic       Out_Last;
   logic [7:0] Sym_Count;

   modport master (
      output In_Valid, In_Bit, Flush,
      input  Out_Valid, Out_Bit, Out_Last, Sym_Count
   );

   modport slave (
      input  In_Valid, In_Bit, Flush,
      output Out_Valid, Out_Bit, Out_Last, Sym_Count
   );
endinterface

// File: rtl/deinterleaver.sv
// 802.11a BPSK rate-1/2 receive deinterleaver. Interleaved coded bits are written
// into a ping-pong buffer at their de-interleaved address; each completed symbol
// is then streamed out in original coded order at one bit per Clock2 cycle.
module deinterleaver #(
   parameter int unsigned N_CBPS = 48,
   parameter int unsigned N_COL  = 16
) (
   input  logic           Clock2,
   input  logic           Reset,
   deinterleaver_if.slave bus
);

   localparam int unsigned N_ROW = N_CBPS / N_COL;
   localparam int unsigned CW    = $clog2(N_CBPS);
   localparam int unsigned RW    = (N_ROW > 1) ? $clog2(N_ROW) : 1;
   localparam int unsigned AW    = (N_COL > 1) ? $clog2(N_COL) : 1;

   localparam logic [0:0] R_IDLE  = 1'b0;
   localparam logic [0:0] R_DRAIN = 1'b1;

   logic [N_CBPS-1:0] mem_q [0:1];

   logic [RW-1:0] wr_row_q, wr_row_d;     // b: row within current column
   logic [AW-1:0] wr_col_q, wr_col_d;     // a: column
   logic [CW-1:0] wr_addr_q, wr_addr_d;   // k = N_COL*b + a, tracked incrementally
   logic          wr_bank_q, wr_bank_d;
   logic          sym_ready;

   logic [0:0]    state_q, state_d;
   logic          rd_bank_q, rd_bank_d;
   logic [CW-1:0] rd_cnt_q, rd_cnt_d;
   logic          out_valid_q, out_valid_d;
   logic          out_bit_q, out_bit_d;
   logic          out_last_q, out_last_d;
   logic [7:0]    sym_cnt_q, sym_cnt_d;

   // Write address walk: stepping b adds N_COL to k; wrapping b restarts k at the new a.
   always_comb begin
      wr_row_d  = wr_row_q;
      wr_col_d  = wr_col_q;
      wr_addr_d = wr_addr_q;
      wr_bank_d = wr_bank_q;
      sym_ready = 1'b0;
      if (bus.Flush) begin
         wr_row_d  = '0;
         wr_col_d  = '0;
         wr_addr_d = '0;
         wr_bank_d = 1'b0;
      end else if (bus.In_Valid) begin
         if (wr_row_q == RW'(N_ROW - 1)) begin
            wr_row_d = '0;
            if (wr_col_q == AW'(N_COL - 1)) begin
               wr_col_d  = '0;
               wr_addr_d = '0;
               wr_bank_d = ~wr_bank_q;
               sym_ready = 1'b1;
            end else begin
               wr_col_d  = wr_col_q + AW'(1);
               wr_addr_d = CW'(wr_col_q) + CW'(1);
            end
         end else begin
            wr_row_d  = wr_row_q + RW'(1);
            wr_addr_d = wr_addr_q + CW'(N_COL);
         end
      end
   end

   // Drain sequencing and registered output values for the next edge.
   always_comb begin
      state_d     = state_q;
      rd_bank_d   = rd_bank_q;
      rd_cnt_d    = rd_cnt_q;
      out_valid_d = 1'b0;
      out_bit_d   = 1'b0;
      out_last_d  = 1'b0;
      sym_cnt_d   = sym_cnt_q;
      if (bus.Flush) begin
         state_d   = R_IDLE;
         rd_cnt_d  = '0;
         sym_cnt_d = '0;
      end else begin
         case (state_q)
            R_IDLE: begin
               if (sym_ready) begin
                  state_d   = R_DRAIN;
                  rd_bank_d = wr_bank_q;
                  rd_cnt_d  = '0;
               end
            end
            R_DRAIN: begin
               out_valid_d = 1'b1;
               out_bit_d   = mem_q[rd_bank_q][rd_cnt_q];
               out_last_d  = (rd_cnt_q == CW'(N_CBPS - 1));
               if (rd_cnt_q == CW'(N_CBPS - 1)) begin
                  sym_cnt_d = sym_cnt_q + 8'd1;
                  rd_cnt_d  = '0;
                  // a symbol finishing filling now chains straight into the next drain
                  if (sym_ready) begin
                     rd_bank_d = wr_bank_q;
                  end else begin
                     state_d = R_IDLE;
                  end
               end else begin
                  rd_cnt_d = rd_cnt_q + CW'(1);
               end
            end
            default: state_d = R_IDLE;
         endcase
      end
   end

   // Buffer write; contents need no reset.
   always_ff @(posedge Clock2) begin
      if (bus.In_Valid && !bus.Flush) begin
         mem_q[wr_bank_q][wr_addr_q] <= bus.In_Bit;
      end
   end

   // State and output registers.
   always_ff @(posedge Clock2 or posedge Reset) begin
      if (Reset) begin
         wr_row_q    <= '0;
         wr_col_q    <= '0;
         wr_addr_q   <= '0;
         wr_bank_q   <= 1'b0;
         state_q     <= R_IDLE;
         rd_bank_q   <= 1'b0;
         rd_cnt_q    <= '0;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
         out_last_q  <= 1'b0;
         sym_cnt_q   <= '0;
      end else begin
         wr_row_q    <= wr_row_d;
         wr_col_q    <= wr_col_d;
         wr_addr_q   <= wr_addr_d;
         wr_bank_q   <= wr_bank_d;
         state_q     <= state_d;
         rd_bank_q   <= rd_bank_d;
         rd_cnt_q    <= rd_cnt_d;
         out_valid_q <= out_valid_d;
         out_bit_q   <= out_bit_d;
         out_last_q  <= out_last_d;
         sym_cnt_q   <= sym_cnt_d;
      end
   end

   assign bus.Out_Valid = out_valid_q;
   assign bus.Out_Bit   = out_bit_q;
   assign bus.Out_Last  = out_last_q;
   assign bus.Sym_Count = sym_cnt_q;

endmodule

// File: tb/tb_deinterleaver.sv
// Bench for deinterleaver: queue-based reference model checked every cycle,
// plus literal expectations for bit positions, latency and symbol counts.
module tb_deinterleaver;

   logic Clock2 = 1'b0;
   logic Reset  = 1'b1;

   deinterleaver_if bus ();

   deinterleaver #(.N_CBPS(48), .N_COL(16)) dut (
      .Clock2 (Clock2),
      .Reset  (Reset),
      .bus    (bus)
   );

   always #5 Clock2 = ~Clock2;

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Reference model: collect 48 interleaved bits, reorder with k=16*(j%3)+j/3,
   // queue them; one queued bit leaves per edge starting the edge after completion.
   logic [1:0] pend[$];
   logic       fill[48];
   logic       ord[48];
   int         fill_n;
   logic       m_valid, m_bit, m_last;
   logic [7:0] m_cnt;

   always @(posedge Clock2 or posedge Reset) begin
      logic [1:0] e;
      if (Reset) begin
         pend.delete();
         fill_n = 0;
         m_valid = 0; m_bit = 0; m_last = 0; m_cnt = 0;
      end else if (bus.Flush) begin
         pend.delete();
         fill_n = 0;
         m_valid = 0; m_bit = 0; m_last = 0; m_cnt = 0;
      end else begin
         if (pend.size() > 0) begin
            e = pend.pop_front();
            m_valid = 1; m_bit = e[0]; m_last = e[1];
            if (e[1]) m_cnt = m_cnt + 8'd1;
         end else begin
            m_valid = 0; m_bit = 0; m_last = 0;
         end
         if (bus.In_Valid) begin
            fill[fill_n] = bus.In_Bit;
            fill_n++;
            if (fill_n == 48) begin
               for (int j = 0; j < 48; j++) ord[16 * (j % 3) + j / 3] = fill[j];
               for (int k = 0; k < 48; k++) pend.push_back({(k == 47), ord[k]});
               fill_n = 0;
            end
         end
      end
   end

   // Every-cycle compare plus capture of each drained symbol by output position.
   logic [47:0] work, cap;
   int          pos = 0, last_pos = -1;
   int          cyc = 0, vcnt = 0, vfirst = -1, vlast = -1;

   always @(negedge Clock2) begin
      cyc++;
      if (!Reset) begin
         chk("out_valid", 64'(bus.Out_Valid), 64'(m_valid));
         chk("out_bit",   64'(bus.Out_Bit),   64'(m_bit));
         chk("out_last",  64'(bus.Out_Last),  64'(m_last));
         chk("sym_count", 64'(bus.Sym_Count), 64'(m_cnt));
      end
      if (bus.Out_Valid) begin
         vcnt++;
         if (vfirst < 0) vfirst = cyc;
         vlast = cyc;
         if (pos < 48) work[pos] = bus.Out_Bit;
         if (bus.Out_Last) begin
            cap = work; last_pos = pos; pos = 0;
         end else pos++;
      end else pos = 0;
   end

   task automatic send_sym(input logic [47:0] b, input int n, input int gap);
      for (int j = 0; j < n; j++) begin
         @(negedge Clock2);
         bus.In_Valid = 1'b1; bus.In_Bit = b[j];
         for (int g = 0; g < gap; g++) begin
            @(negedge Clock2);
            bus.In_Valid = 1'b0; bus.In_Bit = 1'b0;
         end
      end
   endtask

   task automatic idle();
      @(negedge Clock2);
      bus.In_Valid = 1'b0; bus.In_Bit = 1'b0;
   endtask

   task automatic do_flush();
      @(negedge Clock2);
      bus.Flush = 1'b1; bus.In_Valid = 1'b1; bus.In_Bit = 1'b1;
      @(negedge Clock2);
      bus.Flush = 1'b0; bus.In_Valid = 1'b0; bus.In_Bit = 1'b0;
   endtask

   // Transmit interleaver: coded bit k goes to position 3*(k%16)+k/16.
   function automatic logic [47:0] tx_il(input logic [47:0] d);
      logic [47:0] r;
      r = '0;
      for (int k = 0; k < 48; k++) r[3 * (k % 16) + k / 16] = d[k];
      return r;
   endfunction

   initial begin
      logic [47:0] d, d_last;
      bit          seen;
      bus.In_Valid = 1'b0; bus.In_Bit = 1'b0; bus.Flush = 1'b0;
      repeat (3) @(negedge Clock2);
      chk("rst_valid", 64'(bus.Out_Valid), 64'd0);
      chk("rst_bit",   64'(bus.Out_Bit),   64'd0);
      chk("rst_last",  64'(bus.Out_Last),  64'd0);
      chk("rst_count", 64'(bus.Sym_Count), 64'd0);
      Reset = 1'b0;
      repeat (2) @(negedge Clock2);

      // T1: j=1 -> position 16, plus first-output latency
      send_sym(48'h2, 48, 0);
      @(posedge Clock2); #1;
      chk("lat_capture_edge", 64'(bus.Out_Valid), 64'd0);
      @(negedge Clock2); bus.In_Valid = 1'b0; bus.In_Bit = 1'b0;
      @(posedge Clock2); #1;
      chk("lat_first_valid", 64'(bus.Out_Valid), 64'd1);
      repeat (55) @(negedge Clock2);
      chk("t1_pos16", 64'(cap), 64'h0000_0001_0000);
      chk("t1_last_pos", 64'(last_pos), 64'd47);
      chk("t1_count", 64'(bus.Sym_Count), 64'd1);

      // T2: j=3 -> position 1, j=47 -> position 47
      send_sym(48'h8, 48, 0); idle();
      repeat (55) @(negedge Clock2);
      chk("t2_pos1", 64'(cap), 64'h0000_0000_0002);
      send_sym(48'h8000_0000_0000, 48, 0); idle();
      repeat (55) @(negedge Clock2);
      chk("t2_pos47", 64'(cap), 64'h8000_0000_0000);
      chk("t2_count", 64'(bus.Sym_Count), 64'd3);

      // T4: In_Valid alternating, two symbols
      send_sym(tx_il(48'hA5C3_0F96_1E2D), 48, 1);
      send_sym(tx_il(48'h1234_5678_9ABC), 48, 1); idle();
      repeat (55) @(negedge Clock2);
      chk("t4_data", 64'(cap), 64'h1234_5678_9ABC);
      chk("t4_count", 64'(bus.Sym_Count), 64'd5);

      // T3: 10 back-to-back random symbols through the transmit interleaver
      do_flush();
      chk("flush_count", 64'(bus.Sym_Count), 64'd0);
      @(posedge Clock2);
      vcnt = 0; vfirst = -1; vlast = -1;
      d_last = '0;
      for (int s = 0; s < 10; s++) begin
         d = {16'($urandom), $urandom};
         d_last = d;
         send_sym(tx_il(d), 48, 0);
      end
      idle();
      repeat (55) @(negedge Clock2);
      chk("t3_identity", 64'(cap), 64'(d_last));
      chk("t3_valid_cycles", 64'(vcnt), 64'd480);
      chk("t3_continuous", 64'(vlast - vfirst), 64'd479);
      chk("t3_count", 64'(bus.Sym_Count), 64'd10);

      // T5: flush after 20 bits, then a fresh symbol
      send_sym(48'hFFFF_FFFF_FFFF, 20, 0);
      do_flush();
      send_sym(48'h2, 48, 0); idle();
      repeat (55) @(negedge Clock2);
      chk("t5_pos16", 64'(cap), 64'h0000_0001_0000);
      chk("t5_count", 64'(bus.Sym_Count), 64'd1);

      // T6: reset at output position 10, then a clean symbol
      send_sym(48'hFFFF_FFFF_FFFF, 48, 0); idle();
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (bus.Out_Valid) seen = 1;
         else @(negedge Clock2);
      end
      chk("t6_drain_started", 64'(seen), 64'd1);
      repeat (10) @(negedge Clock2);
      #2 Reset = 1'b1;
      #1;
      chk("t6_rst_valid", 64'(bus.Out_Valid), 64'd0);
      chk("t6_rst_bit",   64'(bus.Out_Bit),   64'd0);
      chk("t6_rst_last",  64'(bus.Out_Last),  64'd0);
      chk("t6_rst_count", 64'(bus.Sym_Count), 64'd0);
      @(negedge Clock2); Reset = 1'b0;
      send_sym(48'h8, 48, 0); idle();
      repeat (55) @(negedge Clock2);
      chk("t6_pos1", 64'(cap), 64'h0000_0000_0002);
      chk("t6_count", 64'(bus.Sym_Count), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
